// File: rtl/serial_packet_rx_fifo.sv
`timescale 1ns/1ps
// serial_packet_rx_fifo
// Receives clock/data serial packets oversampled on f_clk, deframes
// {start=1, DATA_W data MSB first, parity, stop=0}, rejects bad packets with
// an error code and buffers good payloads in a ready/valid output FIFO.
// Ports:
//   f_clk, rst_n           system clock, async active-low reset
//   clk, data              serial link (asynchronous to f_clk)
//   out_data/valid/ready   FIFO head, handshake pop
//   fifo_level             entries held
//   err_valid, err_code    reject pulse, {timeout, ctrl_lsb, parity, ctrl_msb}
//   err_count              saturating reject counter
//   overflow               good packet dropped on a full FIFO
module serial_packet_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic                          f_clk,
  input  logic                          rst_n,
  input  logic                          clk,
  input  logic                          data,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_valid,
  output logic [3:0]                    err_code,
  output logic [CNT_W-1:0]              err_count,
  output logic                          overflow
);
  localparam int FRAME = DATA_W + 3;
  localparam int BCW   = $clog2(FRAME + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic PODD = (PARITY_ODD != 0);

  typedef enum logic {IDLE, RX} state_t;

  // synchronisers and edge detect
  logic [1:0] clk_sync, data_sync;
  logic       clk_prev;
  logic       edge_det, rx_bit;

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_prev  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], clk};
      data_sync <= {data_sync[0], data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign edge_det = clk_sync[1] & ~clk_prev;
  assign rx_bit   = data_sync[1];

  // deframer state
  state_t          state;
  logic [BCW-1:0]  bit_cnt;
  logic [TW-1:0]   tmo_cnt;
  logic [DATA_W:0] shreg;     // data bits then parity bit; stop bit is never stored
  logic            msb_err;

  logic last, par_err, lsb_err, frame_err, tmo_hit, push, pop, full, accept;

  // last is the edge carrying the stop bit; shreg already holds data+parity
  assign last      = (state == RX) && edge_det && (bit_cnt == BCW'(FRAME - 1));
  assign par_err   = ((^shreg) != PODD);
  assign lsb_err   = rx_bit;
  assign frame_err = msb_err | par_err | lsb_err;
  assign tmo_hit   = (state == RX) && !edge_det && (tmo_cnt == TW'(TIMEOUT - 1));

  assign push   = last && !frame_err;
  assign pop    = out_valid && out_ready;
  assign full   = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign accept = push && (!full || pop);

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      shreg     <= '0;
      msb_err   <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      err_code  <= '0;
      overflow  <= push && full && !pop;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (edge_det) begin
            // start bit is only recorded; the frame is still taken in full
            msb_err <= !rx_bit;
            bit_cnt <= BCW'(1);
            state   <= RX;
          end
        end
        RX: begin
          if (edge_det) begin
            tmo_cnt <= '0;
            if (last) begin
              state   <= IDLE;
              bit_cnt <= '0;
              if (frame_err) begin
                err_valid <= 1'b1;
                err_code  <= {1'b0, lsb_err, par_err, msb_err};
                if (err_count != '1) err_count <= err_count + 1'b1;
              end
            end else begin
              shreg   <= {shreg[DATA_W-1:0], rx_bit};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (tmo_hit) begin
            err_valid <= 1'b1;
            err_code  <= 4'b1000;
            if (err_count != '1) err_count <= err_count + 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  always_ff @(posedge f_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shreg[DATA_W:1];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = mem[rd_ptr];

endmodule
